prime_sieve_ctrl: RTL and testbench
===================================

// Module: prime_sieve_ctrl
// PURPOSE
//  Sequencer for the sieve-of-Eratosthenes datapath. Replaces a flop-array sieve with an
//  external 1-bit synchronous RAM. Runs three phases per start: clear, mark composites, scan.
//  Then streams primes 2..N, ascending, through a valid/ready port; the display stage's
//  tick drives ready. Sits between the bit RAM and the BCD/display path.
// PARAMETERS
//  N    999999  upper bound, inclusive; legal range 2..2^AW-1; RAM depth is N+1
//  AW   20      address/data width; must satisfy N < 2^AW
// PORTS
//  clk          in   1    system clock, single domain
//  rst          in   1    asynchronous, active-high reset
//  start        in   1    1-cycle pulse; starts a run; ignored unless state is IDLE or DONE
//  busy         out  1    high while state is not IDLE and not DONE
//  done         out  1    high in DONE, after the last prime has been accepted
//  ram_addr     out  AW   RAM address
//  ram_we       out  1    RAM write enable; write occurs at this clk edge
//  ram_wdata    out  1    RAM write data; 1 = composite
//  ram_rdata    in   1    RAM read data; valid 1 cycle after ram_addr is presented, we=0
//  prime_valid  out  1    prime_data holds the next prime
//  prime_ready  in   1    consumer accept (display tick)
//  prime_data   out  AW   current prime
//  prime_last   out  1    qualifies prime_data as the largest prime <= N
//  prime_count  out  AW   number of primes accepted so far in this run
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; i, j, k counters = 0.
//  FSM states and transitions:
//   IDLE/DONE --start--> CLEAR; k=0.
//   CLEAR: we=1, wdata=0, addr=k, one address per cycle over 0..N (N+1 cycles).
//          After k=N, go to ORD with i=2.
//   ORD:   if i*i > N, go to SRD with k=2. Else addr=i, we=0, go to OCHK.
//          The product is computed at 2*AW bits with no truncation.
//   OCHK:  rdata (mark of i) is now valid. If 0, go to INNER with j=i+i.
//          If 1, set i=i+1 and go to ORD.
//   INNER: while j <= N: we=1, wdata=1, addr=j, j=j+i, one write per cycle.
//          When j > N: we=0, i=i+1, go to ORD. j is computed at AW+1 bits so it cannot wrap.
//   SRD:   if k > N, go to DONE. Else addr=k, we=0, go to SCHK.
//   SCHK:  if rdata=0: prime_data=k, prime_valid=1, go to OUT.
//          prime_last=1 when no prime exists in k+1..N; found by a look-ahead scan, below.
//          If rdata=1: k=k+1, go to SRD.
//   OUT:   hold prime_valid, prime_data and prime_last stable until prime_valid&prime_ready.
//          On that cycle: prime_valid=0, prime_count+1, k=k+1, go to SRD.
//          If prime_last was 1, go to DONE instead.
//  prime_last: after a prime is found, scan ahead while holding OUT, using the same RAM port.
//   Simpler option: defer last-detection. Present prime_last=0 in OUT. Assert done in DONE.
//   Decided: prime_last is dropped from the handshake. prime_last=1 only for one cycle
//   together with done; it is not qualified by prime_valid.
//  ready asserted before valid has no effect. No combinational ready->valid path.
//  we is 0 in every state except CLEAR and INNER. ram_addr stays at its last value when we=0.
//  start while busy: ignored; no effect on any output.
//  start in DONE: restarts the run; prime_count resets to 0 on entering CLEAR.
//  rst mid-run: immediate return to IDLE. RAM contents are undefined; the next run clears it.
//  N=2: ORD exits at once (4>2). Output is one prime, 2, then DONE.
// STRUCTURE
//  Shared package sieve_pkg: state encoding localparams (IDLE, CLEAR, ORD, OCHK, INNER,
//  SRD, SCHK, OUT, DONE) and AW.
//  One sub-module: prime_bit_ram (1-bit wide, depth N+1, one port, sync read, write-first).
//  The bench instantiates prime_bit_ram alongside the controller.
//  The controller itself is a single FSM plus counters i, j, k and prime_count.
// TESTING
//  N=30, prime_ready tied 1 -> prime stream 2,3,5,7,11,13,17,19,23,29; prime_count=10;
//   done=1 and busy=0 afterwards.
//  N=30, ready pulsed 1 cycle every 7 -> identical stream. prime_data is stable while
//   valid&!ready. Exactly one count increment per accepted prime.
//  N=2 -> single prime 2, then done. N=4 -> 2 then 3. RAM address never exceeds N.
//  Pulse start during INNER -> no restart; a second start in DONE repeats the identical
//   stream with prime_count restarting at 0.
//  Assert rst during INNER at N=100 -> next cycle: IDLE, all outputs 0. A fresh start
//   yields 25 primes ending at 97.
//  Scoreboard: bench golden sieve at N=1000 -> 168 primes, last 997.
//   No write while in SRD/SCHK/OUT; the CLEAR phase lasts exactly N+1 cycles.

Source files
------------

// File: rtl/sieve_pkg.sv
// Shared constants for the sieve sequencer: default widths and FSM state encoding.
package sieve_pkg;

    localparam int SIEVE_AW = 20;
    localparam int SIEVE_N  = 999999;
    localparam int STW      = 4;

    // State encoding kept as plain constants so older netlists and probes keep matching.
    localparam logic [STW-1:0] IDLE  = 4'd0;
    localparam logic [STW-1:0] CLEAR = 4'd1;
    localparam logic [STW-1:0] ORD   = 4'd2;
    localparam logic [STW-1:0] OCHK  = 4'd3;
    localparam logic [STW-1:0] INNER = 4'd4;
    localparam logic [STW-1:0] SRD   = 4'd5;
    localparam logic [STW-1:0] SCHK  = 4'd6;
    localparam logic [STW-1:0] OUT   = 4'd7;
    localparam logic [STW-1:0] DONE  = 4'd8;

    // A run is in flight in every state except the two resting ones.
    function automatic logic st_running(input logic [STW-1:0] st);
        return !(st == IDLE || st == DONE);
    endfunction

endpackage

// File: rtl/prime_sieve_ctrl_if.sv
// Prime output stream: valid/ready handshake plus the running accepted count.
interface prime_sieve_ctrl_if #(
    parameter int AW = sieve_pkg::SIEVE_AW
);
    logic          prime_valid;
    logic          prime_ready;
    logic [AW-1:0] prime_data;
    logic          prime_last;
    logic [AW-1:0] prime_count;

    // Controller side produces primes.
    modport master (
        output prime_valid,
        output prime_data,
        output prime_last,
        output prime_count,
        input  prime_ready
    );

    // Display side consumes primes and paces them with its tick.
    modport slave (
        input  prime_valid,
        input  prime_data,
        input  prime_last,
        input  prime_count,
        output prime_ready
    );
endinterface

// File: rtl/prime_bit_ram.sv
// Single-port 1-bit sieve RAM: synchronous read, write-first on the shared port.
module prime_bit_ram
    import sieve_pkg::*;
#(
    parameter int AW    = SIEVE_AW,
    parameter int DEPTH = SIEVE_N + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wdata,
    output logic          rdata
);

    logic mem [DEPTH];

    // Write-first: a written bit is also returned on the read port next cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/prime_sieve_ctrl.sv
// Sieve-of-Eratosthenes sequencer over an external 1-bit RAM:
// clear 0..N, mark composites of every unmarked i with i*i <= N, then scan
// 2..N and stream each unmarked index through the valid/ready port.
module prime_sieve_ctrl
    import sieve_pkg::*;
#(
    parameter int N  = SIEVE_N,
    parameter int AW = SIEVE_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_we,
    output logic               ram_wdata,
    input  logic               ram_rdata,
    prime_sieve_ctrl_if.master ps
);

    // N at the widths it is compared against; k and j carry an extra bit so
    // stepping past N can never wrap back into range.
    localparam logic [AW:0]     N_K  = (AW+1)'(N);
    localparam logic [2*AW-1:0] N_SQ = (2*AW)'(N);

    logic [STW-1:0]  state;
    logic [STW-1:0]  state_nx;
    logic [AW-1:0]   i;
    logic [AW:0]     j;
    logic [AW:0]     k;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic            last_q;
    logic [2*AW-1:0] i_sq;
    logic            i_done;
    logic            j_done;
    logic            k_done;

    assign i_sq   = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
    assign i_done = i_sq > N_SQ;
    assign j_done = j > N_K;
    assign k_done = k > N_K;

    // Next-state decode; start is only honoured while resting.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = CLEAR;
            CLEAR:      if (k == N_K) state_nx = ORD;
            ORD:        state_nx = i_done ? SRD : OCHK;
            OCHK:       state_nx = ram_rdata ? ORD : INNER;
            INNER:      if (j_done) state_nx = ORD;
            SRD:        state_nx = k_done ? DONE : SCHK;
            SCHK:       state_nx = ram_rdata ? SRD : OUT;
            OUT:        if (ps.prime_ready) state_nx = SRD;
            default:    state_nx = IDLE;
        endcase
    end

    // State register; reset lands in IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Sieve counters: i = current base, j = multiple being marked,
    // k = clear address and later scan position, cnt = accepted primes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        k   <= '0;
                        cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (k == N_K) i <= AW'(2);
                    else          k <= k + 1'b1;
                end
                ORD: begin
                    if (i_done) k <= (AW+1)'(2);
                end
                OCHK: begin
                    if (ram_rdata) i <= i + 1'b1;
                    else           j <= {1'b0, i} + {1'b0, i};
                end
                INNER: begin
                    if (j_done) i <= i + 1'b1;
                    else        j <= j + {1'b0, i};
                end
                SCHK: begin
                    if (ram_rdata) k <= k + 1'b1;
                end
                OUT: begin
                    if (ps.prime_ready) begin
                        k   <= k + 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM port: the address is presented in the same cycle as the state that
    // needs it so read data lines up with the following check state. Out of
    // range indices never reach the port; the last address is held instead.
    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        case (state)
            CLEAR: begin
                ram_addr = k[AW-1:0];
                ram_we   = 1'b1;
            end
            ORD: begin
                if (!i_done) ram_addr = i;
            end
            INNER: begin
                if (!j_done) begin
                    ram_addr  = j[AW-1:0];
                    ram_we    = 1'b1;
                    ram_wdata = 1'b1;
                end
            end
            SRD: begin
                if (!k_done) ram_addr = k[AW-1:0];
            end
            default: ;
        endcase
    end

    // Hold register behind the address mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= ram_addr;
    end

    // prime_last is a one-cycle marker on the first DONE cycle, outside the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= (state_nx == DONE) && (state != DONE);
    end

    assign busy           = st_running(state);
    assign done           = (state == DONE);
    assign ps.prime_valid = (state == OUT);
    assign ps.prime_data  = k[AW-1:0];
    assign ps.prime_last  = last_q;
    assign ps.prime_count = cnt;

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// Bench: five controller+RAM pairs at N = 2, 4, 30, 100, 1000, checked against
// a trial-division prime model with fixed, pulsed and random consumer pacing.
`timescale 1ns/1ps
module tb_prime_sieve_ctrl;
    import sieve_pkg::*;

    localparam int AW = 11;
    localparam int NI = 5;

    function automatic int n_of(input int g);
        case (g)
            0:       return 2;
            1:       return 4;
            2:       return 30;
            3:       return 100;
            default: return 1000;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a [NI];
    logic          ready_a [NI];
    logic          busy_a  [NI];
    logic          done_a  [NI];
    logic          we_a    [NI];
    logic          wdata_a [NI];
    logic          rdata_a [NI];
    logic          valid_a [NI];
    logic          last_a  [NI];
    logic [AW-1:0] addr_a  [NI];
    logic [AW-1:0] data_a  [NI];
    logic [AW-1:0] cnt_a   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int NG = n_of(g);
        prime_sieve_ctrl_if #(.AW(AW)) ps ();
        prime_sieve_ctrl #(.N(NG), .AW(AW)) dut (
            .clk(clk), .rst(rst), .start(start_a[g]), .busy(busy_a[g]), .done(done_a[g]),
            .ram_addr(addr_a[g]), .ram_we(we_a[g]), .ram_wdata(wdata_a[g]),
            .ram_rdata(rdata_a[g]), .ps(ps));
        prime_bit_ram #(.AW(AW), .DEPTH(NG + 1)) ram (
            .clk(clk), .we(we_a[g]), .addr(addr_a[g]), .wdata(wdata_a[g]), .rdata(rdata_a[g]));
        assign ps.prime_ready = ready_a[g];
        assign valid_a[g]     = ps.prime_valid;
        assign data_a[g]      = ps.prime_data;
        assign last_a[g]      = ps.prime_last;
        assign cnt_a[g]       = ps.prime_count;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: primes 2..n by trial division.
    int exp_q[$];
    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction
    task automatic build_exp(input int n);
        exp_q.delete();
        for (int v = 2; v <= n; v++) if (is_prime(v)) exp_q.push_back(v);
    endtask

    // Observations from one run.
    int            got_q[$];
    int            clear_len, stab_err, addr_err, wr_err, cnt_err, cnt_start;
    bit            timed_out, last_at_done, last_after, busy_at_done, poked;
    logic [AW-1:0] cnt_done;

    // Pulse start, then watch the instance until done (bounded), recording
    // accepted primes and protocol observations. rmode: 0 tied, 1 every 7th, 2 random.
    task automatic run_stream(input int idx, input int rmode, input int budget, input bit poke);
        int n, cyc;
        bit hold, scan, r;
        logic [AW-1:0] hold_d;
        n = n_of(idx);
        got_q.delete();
        clear_len = 0; stab_err = 0; addr_err = 0; wr_err = 0; cnt_err = 0;
        hold = 1'b0; hold_d = '0; scan = 1'b0; poked = 1'b0; cyc = 0;
        @(negedge clk); start_a[idx] = 1'b1; ready_a[idx] = 1'b0;
        @(negedge clk); start_a[idx] = 1'b0;
        cnt_start = int'(cnt_a[idx]);
        while (done_a[idx] !== 1'b1 && cyc < budget) begin
            if (we_a[idx] === 1'b1 && wdata_a[idx] === 1'b0) clear_len++;
            if (int'(addr_a[idx]) > n) addr_err++;
            if (valid_a[idx] === 1'b1) scan = 1'b1;
            if (scan && we_a[idx] !== 1'b0) wr_err++;
            if (hold && (valid_a[idx] !== 1'b1 || data_a[idx] !== hold_d)) stab_err++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 7 == 6);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready_a[idx] = r;
            if (poke && !poked && we_a[idx] === 1'b1 && wdata_a[idx] === 1'b1) begin
                start_a[idx] = 1'b1;
                poked = 1'b1;
            end else begin
                start_a[idx] = 1'b0;
            end
            if (valid_a[idx] === 1'b1 && r) begin
                if (int'(cnt_a[idx]) != got_q.size()) cnt_err++;
                got_q.push_back(int'(data_a[idx]));
            end
            hold   = (valid_a[idx] === 1'b1) && !r;
            hold_d = data_a[idx];
            @(negedge clk);
            cyc++;
        end
        start_a[idx]  = 1'b0;
        ready_a[idx]  = 1'b0;
        timed_out     = (done_a[idx] !== 1'b1);
        last_at_done  = last_a[idx];
        busy_at_done  = busy_a[idx];
        cnt_done      = cnt_a[idx];
        @(negedge clk);
        last_after    = last_a[idx];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start_a[g] = 1'b0;
            ready_a[g] = 1'b0;
        end
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({busy_a[g], done_a[g], we_a[g], wdata_a[g], valid_a[g], last_a[g],
                 addr_a[g], data_a[g], cnt_a[g]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got busy%b done%b we%b wd%b v%b last%b a%0d d%0d c%0d want all 0",
                         g, busy_a[g], done_a[g], we_a[g], wdata_a[g], valid_a[g], last_a[g],
                         addr_a[g], data_a[g], cnt_a[g]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tied_ready();
        build_exp(30);
        run_stream(2, 0, 2000, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL n30_timeout got no done want done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL n30_len got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[x]) begin
            checks++;
            if (x >= got_q.size() || got_q[x] != exp_q[x]) begin
                errors++;
                $display("FAIL n30_prime[%0d] got %0d want %0d", x, (x < got_q.size()) ? got_q[x] : -1, exp_q[x]);
            end
        end
        checks++; if (int'(cnt_done) != exp_q.size()) begin errors++; $display("FAIL n30_count got %0d want %0d", cnt_done, exp_q.size()); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL n30_busy_at_done got %b want 0", busy_at_done); end
        checks++; if (last_at_done !== 1'b1 || last_after !== 1'b0) begin errors++; $display("FAIL n30_last_pulse got %b%b want 10", last_at_done, last_after); end
        checks++; if (clear_len != 31) begin errors++; $display("FAIL n30_clear_len got %0d want 31", clear_len); end
        checks++; if (cnt_start != 0) begin errors++; $display("FAIL n30_count_start got %0d want 0", cnt_start); end
        checks++; if (addr_err + wr_err + cnt_err != 0) begin errors++; $display("FAIL n30_protocol got addr%0d wr%0d cnt%0d want 0", addr_err, wr_err, cnt_err); end
    endtask

    task automatic test_pulsed_ready();
        build_exp(30);
        run_stream(2, 1, 3000, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL pulsed_timeout got no done want done"); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL pulsed_stream got %p want %p", got_q, exp_q); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL pulsed_stability got %0d changes want 0", stab_err); end
        checks++; if (cnt_err != 0 || int'(cnt_done) != exp_q.size()) begin errors++; $display("FAIL pulsed_count got err%0d final%0d want 0/%0d", cnt_err, cnt_done, exp_q.size()); end
    endtask

    task automatic test_small_n();
        for (int g = 0; g < 2; g++) begin
            build_exp(n_of(g));
            run_stream(g, 2, 500, 1'b0);
            checks++; if (timed_out) begin errors++; $display("FAIL small_timeout[N=%0d] got no done want done", n_of(g)); end
            checks++; if (got_q != exp_q) begin errors++; $display("FAIL small_stream[N=%0d] got %p want %p", n_of(g), got_q, exp_q); end
            checks++; if (addr_err != 0) begin errors++; $display("FAIL small_addr[N=%0d] got %0d over-range want 0", n_of(g), addr_err); end
            checks++; if (clear_len != n_of(g) + 1) begin errors++; $display("FAIL small_clear[N=%0d] got %0d want %0d", n_of(g), clear_len, n_of(g) + 1); end
            checks++; if (last_at_done !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL small_end[N=%0d] got last%b busy%b want 1 0", n_of(g), last_at_done, busy_at_done); end
        end
    endtask

    task automatic test_start_while_busy();
        build_exp(100);
        run_stream(3, 2, 4000, 1'b1);
        checks++; if (!poked) begin errors++; $display("FAIL busy_start_injected got 0 want 1"); end
        checks++; if (timed_out) begin errors++; $display("FAIL busy_start_timeout got no done want done"); end
        checks++; if (clear_len != 101) begin errors++; $display("FAIL busy_start_clear got %0d want 101", clear_len); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL busy_start_stream got %0d primes want %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_restart_in_done();
        build_exp(100);
        run_stream(3, 0, 4000, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout got no done want done"); end
        checks++; if (cnt_start != 0) begin errors++; $display("FAIL restart_count_start got %0d want 0", cnt_start); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL restart_stream got %0d primes want %0d", got_q.size(), exp_q.size()); end
        checks++; if (cnt_err != 0 || int'(cnt_done) != exp_q.size()) begin errors++; $display("FAIL restart_count got err%0d final%0d want 0/%0d", cnt_err, cnt_done, exp_q.size()); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        build_exp(100);
        @(negedge clk); start_a[3] = 1'b1;
        @(negedge clk); start_a[3] = 1'b0;
        cyc = 0;
        while (!(we_a[3] === 1'b1 && wdata_a[3] === 1'b1) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL rst_mid_reach_inner got timeout want INNER"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a[3], done_a[3], we_a[3], wdata_a[3], valid_a[3], last_a[3],
             addr_a[3], data_a[3], cnt_a[3]} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got busy%b we%b a%0d c%0d want all 0", busy_a[3], we_a[3], addr_a[3], cnt_a[3]);
        end
        @(negedge clk);
        rst = 1'b0;
        run_stream(3, 2, 4000, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL rst_mid_rerun_timeout got no done want done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_len got %0d want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] != exp_q[exp_q.size()-1]) begin errors++; $display("FAIL rst_mid_last got %0d want %0d", (got_q.size() > 0) ? got_q[got_q.size()-1] : -1, exp_q[exp_q.size()-1]); end
    endtask

    task automatic test_golden_n1000();
        build_exp(1000);
        run_stream(4, 2, 20000, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL n1000_timeout got no done want done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL n1000_len got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[x]) begin
            if (x >= got_q.size() || got_q[x] != exp_q[x]) begin
                checks++; errors++;
                $display("FAIL n1000_prime[%0d] got %0d want %0d", x, (x < got_q.size()) ? got_q[x] : -1, exp_q[x]);
                break;
            end
        end
        checks++; if (clear_len != 1001) begin errors++; $display("FAIL n1000_clear_len got %0d want 1001", clear_len); end
        checks++; if (wr_err != 0) begin errors++; $display("FAIL n1000_scan_write got %0d writes want 0", wr_err); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL n1000_addr got %0d over-range want 0", addr_err); end
        checks++; if (stab_err != 0 || cnt_err != 0) begin errors++; $display("FAIL n1000_handshake got stab%0d cnt%0d want 0", stab_err, cnt_err); end
        checks++; if (last_at_done !== 1'b1 || last_after !== 1'b0) begin errors++; $display("FAIL n1000_last_pulse got %b%b want 10", last_at_done, last_after); end
    endtask

    initial begin
        test_reset();
        test_tied_ready();
        test_pulsed_ready();
        test_small_n();
        test_start_while_busy();
        test_restart_in_done();
        test_rst_mid();
        test_golden_n1000();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
